// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate self-test.
// Truth tables are indexed by {in1,in2}; bit i is the gate output for vector i.
package gate_bist_pkg;

   localparam int VEC_W    = 2;
   localparam int NUM_VECS = 4;

   localparam logic [3:0] NAND_TT = 4'b0111;
   localparam logic [3:0] AND_TT  = 4'b1000;
   localparam logic [3:0] OR_TT   = 4'b1110;
   localparam logic [3:0] XOR_TT  = 4'b0110;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      CHECK,
      FINISH
   } state_t;

   function automatic logic [2:0] sat_inc(input logic [2:0] v);
      return (v >= 3'd4) ? 3'd4 : v + 3'd1;
   endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Settle countdown: load sets the count, then it decrements once per cycle down to 0.
// expired is high while the count equals 1, i.e. on the last settle cycle.
module bist_settle_timer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_value,
   output logic       expired
);

   logic [3:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign expired = (count == 4'd1);

endmodule

// File: rtl/gate_bist.sv
// Self-test sequencer for a 2-input gate: drives 00,01,10,11, waits SETTLE_CYCLES, compares to EXPECTED.
// Optional per-vector failure log enabled by macro GATE_BIST_FAIL_LOG_EN.
module gate_bist
   import gate_bist_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 1,
   parameter logic [3:0] EXPECTED      = 4'b0111
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       start,
   input  logic       dut_out,
   output logic       dut_in1,
   output logic       dut_in2,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] error_count,
   output logic [3:0] fail_vector
);

   localparam logic [3:0] SETTLE_LV = 4'(SETTLE_CYCLES);

   state_t             state;
   logic [VEC_W-1:0]   index;
   logic               expired;
   logic               mismatch;
   logic               start_acc;
   logic               timer_load;

   assign mismatch   = (dut_out != EXPECTED[index]);
   assign start_acc  = start && ((state == IDLE) || (state == FINISH));
   assign timer_load = (state == DRIVE);

   bist_settle_timer u_settle (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (timer_load),
      .load_value (SETTLE_LV),
      .expired    (expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         index       <= '0;
         dut_in1     <= 1'b0;
         dut_in2     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         error_count <= '0;
      end else begin
         case (state)
            IDLE, FINISH: begin
               if (start) begin
                  state       <= DRIVE;
                  index       <= '0;
                  error_count <= '0;
                  done        <= 1'b0;
                  pass        <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            DRIVE: begin
               {dut_in1, dut_in2} <= index;
               state              <= SETTLE;
            end
            SETTLE: begin
               if (expired) state <= CHECK;
            end
            CHECK: begin
               if (mismatch) error_count <= sat_inc(error_count);
               if (index == VEC_W'(NUM_VECS - 1)) begin
                  state <= FINISH;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  // error_count has not yet absorbed this vector's result
                  pass  <= (error_count == 3'd0) && !mismatch;
               end else begin
                  index <= index + 1'b1;
                  state <= DRIVE;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef GATE_BIST_FAIL_LOG_EN
   logic [3:0] fail_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         fail_q <= '0;
      end else if (start_acc) begin
         fail_q <= '0;
      end else if ((state == CHECK) && mismatch) begin
         fail_q[index] <= 1'b1;
      end
   end

   assign fail_vector = fail_q;
`else
   assign fail_vector = 4'b0000;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// Three gate_bist instances (different settle times / truth tables) checked cycle by cycle
// against a timing-and-count model derived from the vector schedule.
module tb_gate_bist;
   import gate_bist_pkg::*;

   logic clock = 1'b0;
   logic reset_n;
   logic start;

   always #5 clock = ~clock;

   logic [3:0] tt [3];
   logic       d_out [3];
   logic       d_in1 [3];
   logic       d_in2 [3];
   logic       o_busy [3];
   logic       o_done [3];
   logic       o_pass [3];
   logic [2:0] o_ec [3];
   logic [3:0] o_fv [3];
   int         prev_vec [3];

   int checks   = 0;
   int failures = 0;

   assign d_out[0] = tt[0][{d_in1[0], d_in2[0]}];
   assign d_out[1] = tt[1][{d_in1[1], d_in2[1]}];
   assign d_out[2] = tt[2][{d_in1[2], d_in2[2]}];

   gate_bist #(.SETTLE_CYCLES(1), .EXPECTED(NAND_TT)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .start(start), .dut_out(d_out[0]),
      .dut_in1(d_in1[0]), .dut_in2(d_in2[0]), .busy(o_busy[0]), .done(o_done[0]),
      .pass(o_pass[0]), .error_count(o_ec[0]), .fail_vector(o_fv[0]));

   gate_bist #(.SETTLE_CYCLES(3), .EXPECTED(NAND_TT)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .start(start), .dut_out(d_out[1]),
      .dut_in1(d_in1[1]), .dut_in2(d_in2[1]), .busy(o_busy[1]), .done(o_done[1]),
      .pass(o_pass[1]), .error_count(o_ec[1]), .fail_vector(o_fv[1]));

   gate_bist #(.SETTLE_CYCLES(2), .EXPECTED(AND_TT)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .start(start), .dut_out(d_out[2]),
      .dut_in1(d_in1[2]), .dut_in2(d_in2[2]), .busy(o_busy[2]), .done(o_done[2]),
      .pass(o_pass[2]), .error_count(o_ec[2]), .fail_vector(o_fv[2]));

   function automatic int settle_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 2;
   endfunction

   function automatic logic [3:0] exp_of(input int k);
      return (k == 2) ? AND_TT : NAND_TT;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // m = edges since the edge that accepted start; prev = vector still on the pins at m=0
   task automatic check_dut(input int k, input int m, input int prev, input string ctx);
      int v_len, total, vec, errs, fmask;
      logic [3:0] e;
      v_len = 2 + settle_of(k);
      total = 4 * v_len;
      e     = exp_of(k);
      vec   = (m == 0) ? prev : (((m - 1) / v_len > 3) ? 3 : (m - 1) / v_len);
      errs  = 0;
      fmask = 0;
      for (int v = 0; v < 4; v++) begin
         if ((v + 1) * v_len <= m && tt[k][v] != e[v]) begin
            errs++;
            fmask |= (1 << v);
         end
      end
`ifndef GATE_BIST_FAIL_LOG_EN
      fmask = 0;
`endif
      chk($sformatf("%s d%0d m%0d busy", ctx, k, m), int'(o_busy[k]), int'(m < total));
      chk($sformatf("%s d%0d m%0d done", ctx, k, m), int'(o_done[k]), int'(m == total));
      chk($sformatf("%s d%0d m%0d pass", ctx, k, m), int'(o_pass[k]), int'(m == total && errs == 0));
      chk($sformatf("%s d%0d m%0d vec", ctx, k, m), int'({d_in1[k], d_in2[k]}), vec);
      chk($sformatf("%s d%0d m%0d errs", ctx, k, m), int'(o_ec[k]), errs);
      chk($sformatf("%s d%0d m%0d fvec", ctx, k, m), int'(o_fv[k]), fmask);
   endtask

   task automatic check_zero(input string ctx);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s d%0d busy", ctx, k), int'(o_busy[k]), 0);
         chk($sformatf("%s d%0d done", ctx, k), int'(o_done[k]), 0);
         chk($sformatf("%s d%0d pass", ctx, k), int'(o_pass[k]), 0);
         chk($sformatf("%s d%0d in", ctx, k), int'({d_in1[k], d_in2[k]}), 0);
         chk($sformatf("%s d%0d errs", ctx, k), int'(o_ec[k]), 0);
         chk($sformatf("%s d%0d fvec", ctx, k), int'(o_fv[k]), 0);
      end
   endtask

   task automatic do_reset(input string ctx);
      #2;
      reset_n = 1'b0;
      start   = 1'b0;
      #1;
      check_zero(ctx);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) prev_vec[k] = 0;
      // stays idle without start
      for (int c = 0; c < 3; c++) begin
         @(posedge clock);
         #1;
         check_zero({ctx, "_idle"});
      end
   endtask

   // Pulse (or hold) start, then check every DUT after each of ncyc further edges.
   task automatic run(input bit hold, input int ncyc, input string ctx);
      int total, m, prev;
      @(negedge clock);
      start = 1'b1;
      for (int n = 0; n <= ncyc; n++) begin
         @(posedge clock);
         #1;
         if (!hold) start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            total = 4 * (2 + settle_of(k));
            if (hold) begin
               m    = n % (total + 1);
               prev = (n >= total + 1) ? 3 : prev_vec[k];
            end else begin
               m    = (n > total) ? total : n;
               prev = prev_vec[k];
            end
            check_dut(k, m, prev, ctx);
         end
      end
      start = 1'b0;
      if (!hold) begin
         for (int k = 0; k < 3; k++)
            if (ncyc >= 4 * (2 + settle_of(k))) prev_vec[k] = 3;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      start   = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tt[k]       = exp_of(k);
         prev_vec[k] = 0;
      end
      #12;
      check_zero("por");
      @(negedge clock);
      reset_n = 1'b1;

      // ideal gates matching each instance's table
      run(1'b0, 22, "ideal");
      // back-to-back restart from FINISH
      run(1'b0, 22, "ideal2");

      for (int k = 0; k < 3; k++) tt[k] = 4'b1111;
      run(1'b0, 22, "stuck1");
      for (int k = 0; k < 3; k++) tt[k] = 4'b0000;
      run(1'b0, 22, "stuck0");
      for (int k = 0; k < 3; k++) tt[k] = NAND_TT;
      run(1'b0, 22, "nand_all");

      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 3; k++) tt[k] = 4'($urandom_range(0, 15));
         run(1'b0, 22, $sformatf("rand%0d", r));
      end

      for (int k = 0; k < 3; k++) tt[k] = 4'($urandom_range(0, 15));
      run(1'b1, 45, "held");
      do_reset("rst_held");

      // reset during SETTLE of vector 2 on the 3-cycle instance
      for (int k = 0; k < 3; k++) tt[k] = exp_of(k);
      run(1'b0, 12, "partial");
      do_reset("rst_mid");
      run(1'b0, 22, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
